// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer, the ALU and its benches.
// Holds the 4-bit opcode values and the 2-bit sequencer FSM state encoding.
// No ports; import with "import alu_pkg::*;".
package alu_pkg;

    // ALU opcodes. OP_ZERO forces the ALU result to zero and is the idle opcode.
    localparam logic [3:0] OP_SUB  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_ZERO = 4'hf;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU command sequencer: 2**REG_AW entries of DATA_WIDTH bits.
// Ports: clk/rst (sync, active-high, clears all entries); rd_a/rd_b/dbg combinational
// read ports; host write port (host_*) and write-back port (wb_*); write-back wins on address clash.
module alu_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     rd_a_addr,
    output logic [DATA_WIDTH-1:0] rd_a_data,
    input  logic [REG_AW-1:0]     rd_b_addr,
    output logic [DATA_WIDTH-1:0] rd_b_data,
    input  logic [REG_AW-1:0]     dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    input  logic                  host_en,
    input  logic [REG_AW-1:0]     host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  wb_en,
    input  logic [REG_AW-1:0]     wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reads are combinational from the stored array, so a write on the same edge
    // is only visible from the following cycle (read-before-write).
    assign rd_a_data = mem[rd_a_addr];
    assign rd_b_data = mem[rd_b_addr];
    assign dbg_data  = mem[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (host_en) begin
                mem[host_addr] <= host_data;
            end
            // Later non-blocking assignment takes effect: write-back beats host write.
            if (wb_en) begin
                mem[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer in front of a registered ALU: accepts {op, src_a, src_b, dst} on a
// valid/ready handshake, reads operands from the local register file, drives the ALU,
// captures R/flag after ALU_LAT clocks, writes R back to regfile[dst] and returns {R, flag}.
// Ports: clk, rst (sync active-high); cmd_* command handshake; wr_* host preload;
// dbg_addr/dbg_data combinational regfile peek; alu_a/alu_b/alu_op to ALU, alu_r/alu_flag
// from ALU; res_* result handshake. One command in flight, ALU_LAT+3 cycles per command.
// Optional macro ALU_CMD_SEQ_STICKY_FLAG_EN adds flag_sticky (out) and flag_clr (in).
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 2,
    parameter int ALU_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [REG_AW-1:0]     cmd_src_a,
    input  logic [REG_AW-1:0]     cmd_src_b,
    input  logic [REG_AW-1:0]     cmd_dst,
    input  logic                  wr_en,
    input  logic [REG_AW-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [REG_AW-1:0]     dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_r,
    input  logic                  alu_flag,
`ifdef ALU_CMD_SEQ_STICKY_FLAG_EN
    output logic                  flag_sticky,
    input  logic                  flag_clr,
`endif
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_flag
);

    // Counter only needs to hold ALU_LAT-1; keep at least one bit.
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_t              state;
    logic [CNT_W-1:0]        cnt;
    logic [REG_AW-1:0]       dst_q;
    logic [DATA_WIDTH-1:0]   rd_a_data;
    logic [DATA_WIDTH-1:0]   rd_b_data;
    logic                    capture;

    // Result capture and write-back happen on the same edge: last WAIT cycle.
    assign capture = (state == ST_WAIT) && (cnt == '0);

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_AW     (REG_AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rd_a_addr  (cmd_src_a),
        .rd_a_data  (rd_a_data),
        .rd_b_addr  (cmd_src_b),
        .rd_b_data  (rd_b_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .host_en    (wr_en),
        .host_addr  (wr_addr),
        .host_data  (wr_data),
        .wb_en      (capture),
        .wb_addr    (dst_q),
        .wb_data    (alu_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dst_q     <= '0;
            cmd_ready <= 1'b1;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_ZERO;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_a     <= rd_a_data;
                        alu_b     <= rd_b_data;
                        alu_op    <= cmd_op;
                        dst_q     <= cmd_dst;
                        cmd_ready <= 1'b0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // ALU inputs were applied at the IDLE->ISSUE edge; WAIT lasts
                    // ALU_LAT cycles so R is sampled ALU_LAT+1 edges after that.
                    cnt   <= CNT_W'(ALU_LAT - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        res_data  <= alu_r;
                        res_flag  <= alu_flag;
                        res_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_CMD_SEQ_STICKY_FLAG_EN
    // A captured flag sets the sticky bit even when a clear arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_sticky <= 1'b0;
        end else if (capture && alu_flag) begin
            flag_sticky <= 1'b1;
        end else if (flag_clr) begin
            flag_sticky <= 1'b0;
        end
    end
`endif

endmodule
